// File: rtl/rdyack_fifo.sv
// rdyack_fifo: multi-entry elastic buffer with rdy/ack handshake on both sides.
// Occupancy is exposed as o_n / o_full / o_empty for flow-control logic.
//
// Handshake: a side's rdy says a word is offered and its ack says the word
// is taken in this cycle. A word moves only on a cycle where rdy and ack are
// both high at the rising edge of clk. The offering side holds rdy and data
// stable until it sees ack. Here src_ack is produced by the FIFO, and
// dst_ack is produced by the consumer; dst_ack without dst_rdy does nothing.
module rdyack_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int FAST   = 1,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              src_rdy,
   output logic              src_ack,
   input  logic [DATA_W-1:0] src_data,
   output logic              dst_rdy,
   input  logic              dst_ack,
   output logic [DATA_W-1:0] dst_data,
   input  logic              flush,
   output logic [CNT_W-1:0]  o_n,
   output logic              o_full,
   output logic              o_empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wp;
   logic [PTR_W-1:0]  rp;
   logic              room;
   logic              wr_en;
   logic              rd_en;

   // Status flags decode registered occupancy only, so they have no input path.
   assign o_full  = (o_n == CNT_W'(DEPTH));
   assign o_empty = (o_n == '0);

   // With FAST set, a full FIFO still has room when the head leaves this cycle.
   assign room    = (FAST != 0) ? (!o_full || dst_ack) : !o_full;
   assign src_ack = rst && src_rdy && !flush && room;
   assign dst_rdy = !o_empty && !flush;
   assign dst_data = mem[rp];

   assign wr_en = src_ack;
   assign rd_en = dst_ack && dst_rdy;

   // Storage array: written on accepted source words, cleared on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wp] <= src_data;
      end
   end

   // Pointers and occupancy: wrap explicitly at DEPTH-1, flush empties the queue.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp  <= '0;
         rp  <= '0;
         o_n <= '0;
      end else if (flush) begin
         wp  <= '0;
         rp  <= '0;
         o_n <= '0;
      end else begin
         if (wr_en) begin
            wp <= (wp == PTR_W'(DEPTH - 1)) ? '0 : wp + PTR_W'(1);
         end
         if (rd_en) begin
            rp <= (rp == PTR_W'(DEPTH - 1)) ? '0 : rp + PTR_W'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   o_n <= o_n + CNT_W'(1);
            2'b01:   o_n <= o_n - CNT_W'(1);
            default: o_n <= o_n;
         endcase
      end
   end

endmodule

// File: tb/tb_rdyack_fifo.sv
// tb_rdyack_fifo: directed vector table plus a bounded streaming sequence.
// u_fast (DEPTH 4, FAST 1) is the primary target, u_slow (DEPTH 4, FAST 0)
// shows the no-bypass full behaviour, u_d3 (DEPTH 3) covers pointer wrap.
// All three share the same input wires.
module tb_rdyack_fifo;

   logic       clk;
   logic       rst;
   logic       src_rdy;
   logic [7:0] src_data;
   logic       dst_ack;
   logic       flush;

   logic       f_src_ack, f_dst_rdy, f_full, f_empty;
   logic [7:0] f_dst_data;
   logic [2:0] f_o_n;
   logic       s_src_ack, s_dst_rdy, s_full, s_empty;
   logic [7:0] s_dst_data;
   logic [2:0] s_o_n;
   logic       t_src_ack, t_dst_rdy, t_full, t_empty;
   logic [7:0] t_dst_data;
   logic [1:0] t_o_n;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] exp_q[$];

   rdyack_fifo #(.DATA_W(8), .DEPTH(4), .FAST(1)) u_fast (
      .clk(clk), .rst(rst),
      .src_rdy(src_rdy), .src_ack(f_src_ack), .src_data(src_data),
      .dst_rdy(f_dst_rdy), .dst_ack(dst_ack), .dst_data(f_dst_data),
      .flush(flush), .o_n(f_o_n), .o_full(f_full), .o_empty(f_empty)
   );

   rdyack_fifo #(.DATA_W(8), .DEPTH(4), .FAST(0)) u_slow (
      .clk(clk), .rst(rst),
      .src_rdy(src_rdy), .src_ack(s_src_ack), .src_data(src_data),
      .dst_rdy(s_dst_rdy), .dst_ack(dst_ack), .dst_data(s_dst_data),
      .flush(flush), .o_n(s_o_n), .o_full(s_full), .o_empty(s_empty)
   );

   rdyack_fifo #(.DATA_W(8), .DEPTH(3), .FAST(1)) u_d3 (
      .clk(clk), .rst(rst),
      .src_rdy(src_rdy), .src_ack(t_src_ack), .src_data(src_data),
      .dst_rdy(t_dst_rdy), .dst_ack(dst_ack), .dst_data(t_dst_data),
      .flush(flush), .o_n(t_o_n), .o_full(t_full), .o_empty(t_empty)
   );

   // Clock and initial reset level.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      rst      = 1'b0;
      src_rdy  = 1'b0;
      src_data = 8'h00;
      dst_ack  = 1'b0;
      flush    = 1'b0;
   end

   typedef struct packed {
      logic       rst;
      logic       src_rdy;
      logic [7:0] src_data;
      logic       dst_ack;
      logic       flush;
      logic       e_src_ack;
      logic       e_dst_rdy;
      logic       e_dchk;
      logic [7:0] e_data;
      logic [2:0] e_n;
      logic       s_chk;
      logic       s_src_ack;
      logic [2:0] s_n;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic sr, input logic [7:0] sd,
                      input logic ack, input logic fl, input logic e_sack,
                      input logic e_drdy, input logic e_dchk, input logic [7:0] e_data,
                      input logic [2:0] e_n, input logic s_chk, input logic s_sack,
                      input logic [2:0] s_n);
      vec_t v;
      v = '{r, sr, sd, ack, fl, e_sack, e_drdy, e_dchk, e_data, e_n, s_chk, s_sack, s_n};
      vq.push_back(v);
   endtask

   task automatic drive(input logic r, input logic sr, input logic [7:0] sd,
                        input logic ack, input logic fl);
      rst      = r;
      src_rdy  = sr;
      src_data = sd;
      dst_ack  = ack;
      flush    = fl;
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   initial begin
      int sent;
      int got;
      int max_n;
      bit pending;
      bit ack_now;

      // Reset release with a word waiting (A5).
      add(0,1,8'hA5,0,0, 0,0,1,8'h00,0, 0,0,0);
      add(1,1,8'hA5,0,0, 1,0,1,8'h00,0, 0,0,0);
      add(1,0,8'h00,0,0, 0,1,1,8'hA5,1, 0,0,0);
      add(1,0,8'h00,1,0, 0,1,1,8'hA5,1, 0,0,0);
      // Fill 1..4, word 5 refused at full, then drain.
      add(1,1,8'h01,0,0, 1,0,0,8'h00,0, 0,0,0);
      add(1,1,8'h02,0,0, 1,1,1,8'h01,1, 0,0,0);
      add(1,1,8'h03,0,0, 1,1,1,8'h01,2, 0,0,0);
      add(1,1,8'h04,0,0, 1,1,1,8'h01,3, 0,0,0);
      add(1,1,8'h05,0,0, 0,1,1,8'h01,4, 0,0,0);
      add(1,0,8'h00,1,0, 0,1,1,8'h01,4, 0,0,0);
      add(1,0,8'h00,1,0, 0,1,1,8'h02,3, 0,0,0);
      add(1,0,8'h00,1,0, 0,1,1,8'h03,2, 0,0,0);
      add(1,0,8'h00,1,0, 0,1,1,8'h04,1, 0,0,0);
      add(1,0,8'h00,0,0, 0,0,0,8'h00,0, 0,0,0);
      // Full with simultaneous read and write: FAST accepts, slow refuses.
      add(1,1,8'h01,0,0, 1,0,0,8'h00,0, 0,0,0);
      add(1,1,8'h02,0,0, 1,1,1,8'h01,1, 0,0,0);
      add(1,1,8'h03,0,0, 1,1,1,8'h01,2, 0,0,0);
      add(1,1,8'h04,0,0, 1,1,1,8'h01,3, 0,0,0);
      add(1,1,8'h05,1,0, 1,1,1,8'h01,4, 1,0,4);
      add(1,0,8'h00,0,0, 0,1,1,8'h02,4, 1,0,3);
      add(1,0,8'h00,1,0, 0,1,1,8'h02,4, 0,0,0);
      add(1,0,8'h00,1,0, 0,1,1,8'h03,3, 0,0,0);
      add(1,0,8'h00,1,0, 0,1,1,8'h04,2, 0,0,0);
      add(1,0,8'h00,1,0, 0,1,1,8'h05,1, 0,0,0);
      add(1,0,8'h00,0,0, 0,0,0,8'h00,0, 0,0,0);
      // Flush at o_n=3 with src_rdy and dst_ack high, then write 3C.
      add(1,1,8'h11,0,0, 1,0,0,8'h00,0, 0,0,0);
      add(1,1,8'h22,0,0, 1,1,1,8'h11,1, 0,0,0);
      add(1,1,8'h33,0,0, 1,1,1,8'h11,2, 0,0,0);
      add(1,1,8'h44,1,1, 0,0,0,8'h00,3, 0,0,0);
      add(1,1,8'h3C,0,0, 1,0,0,8'h00,0, 0,0,0);
      add(1,0,8'h00,0,0, 0,1,1,8'h3C,1, 0,0,0);
      // Read and write together at o_n=1; ignored dst_ack at empty.
      add(1,1,8'h5A,1,0, 1,1,1,8'h3C,1, 0,0,0);
      add(1,0,8'h00,0,0, 0,1,1,8'h5A,1, 0,0,0);
      add(1,0,8'h00,1,0, 0,1,1,8'h5A,1, 0,0,0);
      add(1,0,8'h00,1,0, 0,0,0,8'h00,0, 0,0,0);
      add(1,1,8'h77,0,0, 1,0,0,8'h00,0, 0,0,0);
      add(1,0,8'h00,0,0, 0,1,1,8'h77,1, 0,0,0);
      add(1,0,8'h00,1,0, 0,1,1,8'h77,1, 0,0,0);
      add(1,0,8'h00,0,0, 0,0,0,8'h00,0, 0,0,0);
      // Async reset mid-operation discards contents and clears storage.
      add(1,1,8'h81,0,0, 1,0,0,8'h00,0, 0,0,0);
      add(1,1,8'h82,0,0, 1,1,1,8'h81,1, 0,0,0);
      add(0,1,8'h83,0,0, 0,0,1,8'h00,0, 0,0,0);
      add(1,0,8'h00,0,0, 0,0,1,8'h00,0, 0,0,0);
      // Flush held for two cycles keeps the FIFO empty and closed.
      add(1,1,8'h99,1,1, 0,0,0,8'h00,0, 0,0,0);
      add(1,1,8'h99,0,1, 0,0,0,8'h00,0, 0,0,0);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         drive(vq[i].rst, vq[i].src_rdy, vq[i].src_data, vq[i].dst_ack, vq[i].flush);
         #2;
         check("src_ack", i, 32'(f_src_ack), 32'(vq[i].e_src_ack));
         check("dst_rdy", i, 32'(f_dst_rdy), 32'(vq[i].e_dst_rdy));
         check("o_n",     i, 32'(f_o_n),     32'(vq[i].e_n));
         check("o_full",  i, 32'(f_full),    32'(vq[i].e_n == 3'd4));
         check("o_empty", i, 32'(f_empty),   32'(vq[i].e_n == 3'd0));
         if (vq[i].e_dchk) begin
            check("dst_data", i, 32'(f_dst_data), 32'(vq[i].e_data));
         end
         if (vq[i].s_chk) begin
            check("slow_src_ack", i, 32'(s_src_ack), 32'(vq[i].s_src_ack));
            check("slow_o_n",     i, 32'(s_o_n),     32'(vq[i].s_n));
         end
      end

      // Streaming 0..9 through the DEPTH=3 instance with random handshakes.
      sent    = 0;
      got     = 0;
      max_n   = 0;
      pending = 1'b0;
      for (int cyc = 0; cyc < 2000 && got < 10; cyc++) begin
         @(negedge clk);
         if (!pending) begin
            if (sent < 10 && $urandom_range(0, 3) != 0) begin
               src_rdy  = 1'b1;
               src_data = 8'(sent);
            end else begin
               src_rdy  = 1'b0;
            end
         end
         ack_now = ($urandom_range(0, 2) == 0);
         dst_ack = ack_now;
         flush   = 1'b0;
         rst     = 1'b1;
         #2;
         if (int'(t_o_n) > max_n) max_n = int'(t_o_n);
         if (t_dst_rdy && ack_now) begin
            if (exp_q.size() == 0) begin
               check("stream_underflow", got, 32'(t_dst_data), 32'hFFFF_FFFF);
            end else begin
               check("stream_data", got, 32'(t_dst_data), 32'(exp_q.pop_front()));
            end
            got++;
         end
         if (t_src_ack) begin
            exp_q.push_back(src_data);
            sent++;
            pending = 1'b0;
         end else begin
            pending = src_rdy;
         end
      end
      @(negedge clk);
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      check("stream_count", 0, 32'(got), 32'd10);
      check("stream_left", 0, 32'(exp_q.size()), 32'd0);
      check("stream_max_n_le_3", 0, 32'(max_n > 3), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
